// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush, optional skid entry
// and a saturating bubble counter for trace/debug.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter int SKID   = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic              in_ready_q,   in_ready_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic              in_xfer, out_xfer;

  // With a skid entry, in_ready is a pure flop so out_ready never reaches upstream.
  assign in_ready  = (SKID != 0) ? in_ready_q : (~main_valid_q | out_ready);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = main_valid_q & out_ready;

  assign out_valid  = main_valid_q;
  assign out_data   = main_data_q;
  assign out_ctrl   = main_valid_q ? main_ctrl_q : '0;
  assign occupancy  = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
  assign bubble_cnt = bubble_cnt_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_ctrl_d  = '0;
    end else if (SKID == 0) begin
      if (in_xfer) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
        main_ctrl_d  = in_ctrl;
      end else if (out_xfer) begin
        main_valid_d = 1'b0;
      end
    end else begin
      if (out_xfer) begin
        if (skid_valid_q) begin
          main_data_d  = skid_data_q;
          main_ctrl_d  = skid_ctrl_q;
          skid_valid_d = 1'b0;
        end else if (in_xfer) begin
          main_data_d  = in_data;
          main_ctrl_d  = in_ctrl;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (in_xfer) begin
        if (!main_valid_q) begin
          main_valid_d = 1'b1;
          main_data_d  = in_data;
          main_ctrl_d  = in_ctrl;
        end else begin
          skid_valid_d = 1'b1;
          skid_data_d  = in_data;
          skid_ctrl_d  = in_ctrl;
        end
      end
    end

    in_ready_d = ~skid_valid_d;

    bubble_cnt_d = bubble_cnt_q;
    if (!main_valid_q && (bubble_cnt_q != '1))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
      in_ready_q   <= 1'b1;
      bubble_cnt_q <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      in_ready_q   <= in_ready_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

endmodule
